pushpop_sequencer: RTL and testbench

Multi-cycle sequencer for Thumb Type 14 PUSH/POP with arbitrary register lists. It replaces the single-register self-instruct path in decode. Decode hands over one PUSH/POP instruction, and the block issues one memory micro-op per listed register, then one SP-update micro-op. Sits between the control unit and the ALU/memory/regfile write-back path; busy_o stalls fetch.

---
 rtl/pushpop_sequencer_pkg.sv | 27 ++
 rtl/pushpop_sequencer_lowest_set_enc.sv | 27 ++
 rtl/pushpop_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_pushpop_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pushpop_sequencer_pkg.sv
// Shared definitions for the Thumb PUSH/POP sequencer: state encoding,
// Type 14 opcode fields and the architectural register indices that the
// control unit also refers to.
package pushpop_sequencer_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_SPUPD = 2'd2
    } state_e;

    // Type 14 (PUSH/POP) opcode fields: instr[15:12] and instr[10:9]
    localparam logic [3:0] T14_OP_HI  = 4'b1011;
    localparam logic [1:0] T14_OP_MID = 2'b10;

    // Architectural register indices
    localparam logic [3:0] SP_IDX = 4'd13;
    localparam logic [3:0] LR_IDX = 4'd14;
    localparam logic [3:0] PC_IDX = 4'd15;

    // True when the halfword carries the PUSH/POP encoding
    function automatic logic is_type14(input logic [15:0] instr);
        return (instr[15:12] == T14_OP_HI) && (instr[10:9] == T14_OP_MID);
    endfunction

endpackage

// File: rtl/pushpop_sequencer_lowest_set_enc.sv
// Lowest-set-bit encoder: returns the index of the least significant set bit
// of vec, plus a flag for an all-zero vector (idx is 0 in that case).
module lowest_set_enc #(
    parameter int NUM_LO_REGS = 8
) (
    input  logic [NUM_LO_REGS-1:0]         vec,
    output logic [$clog2(NUM_LO_REGS)-1:0] idx,
    output logic                           empty
);

    localparam int IDX_W = $clog2(NUM_LO_REGS);

    // Priority scan from the top down so the lowest set bit wins
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, otherwise the unassigned paths infer a latch.
        idx = '0;
        for (int i = NUM_LO_REGS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign empty = ~|vec;

endmodule

// File: rtl/pushpop_sequencer.sv
// Multi-cycle Thumb Type 14 PUSH/POP sequencer. Accepts one instruction in
// IDLE, issues one memory micro-op per listed register (ascending order,
// lowest register at lowest address), then one SP-update micro-op.
// Micro-op outputs are registered from the next-state values, so they appear
// the cycle after accept/handshake and hold still while the consumer stalls.
module pushpop_sequencer
    import pushpop_sequencer_pkg::*;
#(
    parameter int NUM_LO_REGS = 8,
    parameter int WORD_BYTES  = 4,
    parameter int OFF_W       = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [15:0]             instr_i,
    input  logic                    instr_valid_i,
    output logic                    instr_ready_o,
    output logic                    uop_valid_o,
    input  logic                    uop_ready_i,
    output logic [3:0]              uop_reg_o,
    output logic signed [OFF_W-1:0] uop_offset_o,
    output logic                    uop_load_o,
    output logic                    uop_store_o,
    output logic                    sp_write_en_o,
    output logic signed [OFF_W-1:0] sp_delta_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    illegal_o
);

    // Counters must hold up to NUM_LO_REGS+1 transfers
    localparam int CNT_W = $clog2(NUM_LO_REGS + 2);
    localparam int IDX_W = $clog2(NUM_LO_REGS);

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LO_REGS-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_LO_REGS; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // Signed byte offset for a (possibly negative) word count
    function automatic logic signed [OFF_W-1:0] word_off(input int words);
        return OFF_W'(words * WORD_BYTES);
    endfunction

    state_e                  state_q, state_d;
    logic [NUM_LO_REGS-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0]        n_q, n_d;
    logic [CNT_W-1:0]        k_q, k_d;
    logic                    load_q, load_d;
    logic [CNT_W-1:0]        accept_n;
    logic                    illegal_d;

    logic                    valid_d;
    logic [3:0]              reg_d;
    logic signed [OFF_W-1:0] offset_d;
    logic                    uop_load_d;
    logic                    uop_store_d;
    logic                    sp_we_d;
    logic signed [OFF_W-1:0] delta_d;

    logic [IDX_W-1:0]        low_idx;
    logic                    low_empty;

    // Transfer count of the instruction on the input: listed low regs plus R
    assign accept_n = popcount(instr_i[NUM_LO_REGS-1:0]) + CNT_W'(instr_i[8]);

    // The encoder looks at the next mask so the registered register index
    // lines up with the registered micro-op it belongs to.
    lowest_set_enc #(
        .NUM_LO_REGS(NUM_LO_REGS)
    ) u_lowest_set_enc (
        .vec   (mask_d),
        .idx   (low_idx),
        .empty (low_empty)
    );

    // State register and per-instruction context
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            n_q     <= '0;
            k_q     <= '0;
            load_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            mask_q  <= mask_d;
            n_q     <= n_d;
            k_q     <= k_d;
            load_q  <= load_d;
        end
    end

    // Next-state logic: accept/reject in IDLE, step through the list in XFER
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        n_d       = n_q;
        k_d       = k_q;
        load_d    = load_q;
        illegal_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid_i) begin
                    if (is_type14(instr_i) && (accept_n != '0)) begin
                        state_d = ST_XFER;
                        mask_d  = instr_i[NUM_LO_REGS-1:0];
                        n_d     = accept_n;
                        k_d     = '0;
                        load_d  = instr_i[11];
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_XFER: begin
                if (uop_ready_i) begin
                    // Drop the lowest set bit; once empty, the LR/PC slot is next
                    mask_d = mask_q & (mask_q - NUM_LO_REGS'(1));
                    k_d    = k_q + CNT_W'(1);
                    if ((k_q + CNT_W'(1)) == n_q) begin
                        state_d = ST_SPUPD;
                    end
                end
            end
            ST_SPUPD: begin
                if (uop_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Micro-op the block will present next cycle, derived from next state
    always_comb begin
        valid_d     = 1'b0;
        reg_d       = '0;
        offset_d    = '0;
        uop_load_d  = 1'b0;
        uop_store_d = 1'b0;
        sp_we_d     = 1'b0;
        delta_d     = '0;
        unique case (state_d)
            ST_XFER: begin
                valid_d     = 1'b1;
                uop_load_d  = load_d;
                uop_store_d = !load_d;
                if (low_empty) begin
                    reg_d = load_d ? PC_IDX : LR_IDX;
                end else begin
                    reg_d = 4'(low_idx);
                end
                // PUSH fills downward from the old SP; POP reads upward
                offset_d = load_d ? word_off(int'(k_d))
                                  : word_off(int'(k_d) - int'(n_d));
            end
            ST_SPUPD: begin
                valid_d = 1'b1;
                reg_d   = SP_IDX;
                sp_we_d = 1'b1;
                delta_d = load_d ? word_off(int'(n_d)) : word_off(-int'(n_d));
            end
            default: ;
        endcase
    end

    // Registered micro-op and status outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            uop_valid_o   <= 1'b0;
            uop_reg_o     <= '0;
            uop_offset_o  <= '0;
            uop_load_o    <= 1'b0;
            uop_store_o   <= 1'b0;
            sp_write_en_o <= 1'b0;
            sp_delta_o    <= '0;
            illegal_o     <= 1'b0;
        end else begin
            uop_valid_o   <= valid_d;
            uop_reg_o     <= reg_d;
            uop_offset_o  <= offset_d;
            uop_load_o    <= uop_load_d;
            uop_store_o   <= uop_store_d;
            sp_write_en_o <= sp_we_d;
            sp_delta_o    <= delta_d;
            illegal_o     <= illegal_d;
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held
    assign instr_ready_o = (state_q == ST_IDLE) && rst_n_i;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_SPUPD) && uop_ready_i;

endmodule

// File: tb/tb_pushpop_sequencer.sv
// Self-checking bench for pushpop_sequencer. Expected micro-op streams come
// from a list-based model of the PUSH/POP rules; directed cases come first,
// then randomized instructions with random back-pressure and input noise.
module tb_pushpop_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [15:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        uop_ready_i = 1'b0;
    logic        instr_ready_o;
    logic        uop_valid_o;
    logic [3:0]  uop_reg_o;
    logic [7:0]  uop_offset_o;
    logic        uop_load_o;
    logic        uop_store_o;
    logic        sp_write_en_o;
    logic [7:0]  sp_delta_o;
    logic        busy_o;
    logic        done_o;
    logic        illegal_o;

    pushpop_sequencer dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .uop_valid_o   (uop_valid_o),
        .uop_ready_i   (uop_ready_i),
        .uop_reg_o     (uop_reg_o),
        .uop_offset_o  (uop_offset_o),
        .uop_load_o    (uop_load_o),
        .uop_store_o   (uop_store_o),
        .sp_write_en_o (sp_write_en_o),
        .sp_delta_o    (sp_delta_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] r;
        int         off;
        bit         ld;
        bit         sp;
        int         delta;
    } uop_t;

    uop_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expand an instruction into its micro-op list.
    // Returns 0 for anything the block must reject.
    function automatic bit build_model(input logic [15:0] ins);
        int regs[$];
        bit l;
        int n;
        uop_t s;
        exp_q.delete();
        if (ins[15:12] != 4'b1011 || ins[10:9] != 2'b10) return 1'b0;
        l = ins[11];
        for (int i = 0; i < 8; i++) if (ins[i]) regs.push_back(i);
        if (ins[8]) regs.push_back(l ? 15 : 14);
        n = regs.size();
        if (n == 0) return 1'b0;
        foreach (regs[j]) begin
            uop_t u;
            u.r     = 4'(regs[j]);
            u.off   = l ? 4 * j : 4 * (j - n);
            u.ld    = l;
            u.sp    = 1'b0;
            u.delta = 0;
            exp_q.push_back(u);
        end
        s.r     = 4'd13;
        s.off   = 0;
        s.ld    = l;
        s.sp    = 1'b1;
        s.delta = l ? 4 * n : -4 * n;
        exp_q.push_back(s);
        return 1'b1;
    endfunction

    task automatic check_uop(input string tag, input uop_t e);
        check({tag, ".valid"},   32'(uop_valid_o),   32'd1);
        check({tag, ".busy"},    32'(busy_o),        32'd1);
        check({tag, ".irdy"},    32'(instr_ready_o), 32'd0);
        check({tag, ".reg"},     32'(uop_reg_o),     32'(e.r));
        check({tag, ".load"},    32'(uop_load_o),    32'(e.ld && !e.sp));
        check({tag, ".store"},   32'(uop_store_o),   32'(!e.ld && !e.sp));
        check({tag, ".sp_we"},   32'(sp_write_en_o), 32'(e.sp));
        if (e.sp) check({tag, ".delta"},  {24'b0, sp_delta_o},   {24'b0, 8'(e.delta)});
        else      check({tag, ".offset"}, {24'b0, uop_offset_o}, {24'b0, 8'(e.off)});
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".irdy"},  32'(instr_ready_o), 32'd1);
        check({tag, ".valid"}, 32'(uop_valid_o),   32'd0);
        check({tag, ".busy"},  32'(busy_o),        32'd0);
        check({tag, ".done"},  32'(done_o),        32'd0);
    endtask

    // Issue one instruction and follow it to completion. Entered and left on
    // a falling edge. mode 0: always ready; 1: ready 1,0,0 repeating;
    // 2: random ready plus random instruction noise while busy.
    task automatic run_instr(input logic [15:0] ins, input int mode, input string tag);
        bit legal;
        bit rdy;
        int cyc;
        legal = build_model(ins);
        check({tag, ".accept_rdy"}, 32'(instr_ready_o), 32'd1);
        instr_i       = ins;
        instr_valid_i = 1'b1;
        uop_ready_i   = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        if (!legal) begin
            check({tag, ".illegal"}, 32'(illegal_o), 32'd1);
            check_idle({tag, ".rej"});
            @(negedge clk_i);
            check({tag, ".illegal_end"}, 32'(illegal_o), 32'd0);
            check({tag, ".rej_valid"},   32'(uop_valid_o), 32'd0);
            return;
        end
        check({tag, ".no_illegal"}, 32'(illegal_o), 32'd0);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            check_uop(tag, exp_q[0]);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            uop_ready_i = rdy;
            if (mode == 2) begin
                instr_valid_i = 1'($urandom_range(0, 1));
                instr_i       = 16'($urandom);
            end
            #1;
            check({tag, ".done"}, 32'(done_o), 32'(rdy && exp_q[0].sp));
            if (rdy) void'(exp_q.pop_front());
            cyc++;
            @(negedge clk_i);
        end
        instr_valid_i = 1'b0;
        uop_ready_i   = 1'b0;
        check({tag, ".drained"}, 32'(exp_q.size()), 32'd0);
        check_idle({tag, ".after"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ins;
        bit          legal;

        // Reset held: everything low, including ready
        #3;
        check("reset.irdy",  32'(instr_ready_o), 32'd0);
        check("reset.valid", 32'(uop_valid_o),   32'd0);
        #9 rst_n_i = 1'b1;
        @(negedge clk_i);
        check_idle("post_reset");
        check("post_reset.illegal", 32'(illegal_o),     32'd0);
        check("post_reset.load",    32'(uop_load_o),    32'd0);
        check("post_reset.store",   32'(uop_store_o),   32'd0);
        check("post_reset.sp_we",   32'(sp_write_en_o), 32'd0);

        // Directed cases
        run_instr(16'hB505, 0, "push_b505");
        run_instr(16'hBD02, 0, "pop_bd02");
        run_instr(16'hB5FF, 1, "push_b5ff_stall");
        run_instr(16'hB400, 0, "empty_push");
        run_instr(16'h1C08, 0, "not_t14");

        // Reset in the middle of POP {r0-r3}, after two loads
        legal = build_model(16'hBC0F);
        check("rst_seq.legal_model", 32'(legal), 32'd1);
        instr_i       = 16'hBC0F;
        instr_valid_i = 1'b1;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_uop("rst_seq", exp_q[0]);
            uop_ready_i = 1'b1;
            void'(exp_q.pop_front());
            @(negedge clk_i);
        end
        check_uop("rst_seq.third", exp_q[0]);
        uop_ready_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_async.valid", 32'(uop_valid_o),   32'd0);
        check("rst_async.reg",   32'(uop_reg_o),     32'd0);
        check("rst_async.off",   32'(uop_offset_o),  32'd0);
        check("rst_async.load",  32'(uop_load_o),    32'd0);
        check("rst_async.busy",  32'(busy_o),        32'd0);
        check("rst_async.irdy",  32'(instr_ready_o), 32'd0);
        check("rst_async.done",  32'(done_o),        32'd0);
        uop_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_hold.valid", 32'(uop_valid_o), 32'd0);
        #2 rst_n_i = 1'b1;
        @(negedge clk_i);
        check_idle("rst_release");
        uop_ready_i = 1'b0;
        run_instr(16'hBC01, 0, "pop_bc01");

        // Randomized instructions, mostly well-formed PUSH/POP
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) != 0) begin
                ins = {4'b1011, 1'($urandom), 2'b10, 1'($urandom), 8'($urandom)};
                if ($urandom_range(0, 7) == 0) ins[7:0] = 8'h00;
            end else begin
                ins = 16'($urandom);
            end
            run_instr(ins, 2, $sformatf("rand%0d_%04h", t, ins));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
